// File: rtl/conv_window_addr_gen_pkg.sv
// Shared constants for the convolution window address generator: width
// defaults, FSM state encoding and the stride-zero substitution value.
package conv_window_addr_gen_pkg;

  localparam int BW_MAX_IF_SIZE_DEFAULT = 22;
  localparam int BW_MAX_W_SIZE_DEFAULT  = 9;
  localparam int BW_IF_ROWS_DEFAULT     = 10;
  localparam int BW_IF_COLUMS_DEFAULT   = 11;
  localparam int BW_W_COLUMS_DEFAULT    = 4;
  localparam int BW_STRIDE_DEFAULT      = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // A programmed stride of zero walks the image as if the stride were this value.
  localparam int STRIDE_ZERO_AS = 1;

endpackage

// File: rtl/conv_window_addr_gen_wrap_counter.sv
// Loop index counter: counts 0..limit and flags (registered) when it sits at the limit,
// so the next enabled step wraps it back to zero.
module wrap_counter
  import conv_window_addr_gen_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clear,
  input  logic         i_en,
  input  logic [W-1:0] i_limit,
  output logic         o_atLimit
);

  logic [W-1:0] r_count;
  logic         r_atLimit;

  // The limit flag is precomputed one step ahead so no comparator sits on the count output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count   <= '0;
      r_atLimit <= 1'b0;
    end else if (i_clear) begin
      r_count   <= '0;
      r_atLimit <= (i_limit == '0);
    end else if (i_en) begin
      if (r_atLimit) begin
        r_count   <= '0;
        r_atLimit <= (i_limit == '0);
      end else begin
        r_count   <= r_count + 1'b1;
        r_atLimit <= ((r_count + 1'b1) == i_limit);
      end
    end
  end

  assign o_atLimit = r_atLimit;

endmodule

// File: rtl/conv_window_addr_gen.sv
// Walks every output pixel in raster order and streams the IF/weight addresses of its
// convolution window over valid/ready, using only adders once the run has started.
module conv_window_addr_gen
  import conv_window_addr_gen_pkg::*;
#(
  parameter int BITWIDTH_MAX_IF_SIZE = BW_MAX_IF_SIZE_DEFAULT,
  parameter int BITWIDTH_MAX_W_SIZE  = BW_MAX_W_SIZE_DEFAULT,
  parameter int BITWIDTH_IF_ROWS     = BW_IF_ROWS_DEFAULT,
  parameter int BITWIDTH_IF_COLUMS   = BW_IF_COLUMS_DEFAULT,
  parameter int BITWIDTH_W_COLUMS    = BW_W_COLUMS_DEFAULT,
  parameter int BITWIDTH_STRIDE      = BW_STRIDE_DEFAULT
) (
  input  logic                            CONV_WINDOW_ADDR_GEN_CLOCK_50,
  input  logic                            CONV_WINDOW_ADDR_GEN_RESET_InHigh,
  input  logic                            CONV_WINDOW_ADDR_GEN_Start,
  input  logic [BITWIDTH_IF_COLUMS-1:0]   CONV_WINDOW_ADDR_GEN_If_Colums,
  input  logic [BITWIDTH_MAX_IF_SIZE-1:0] CONV_WINDOW_ADDR_GEN_If_RoXCl,
  input  logic [BITWIDTH_IF_ROWS-1:0]     CONV_WINDOW_ADDR_GEN_Of_Rows,
  input  logic [BITWIDTH_IF_COLUMS-1:0]   CONV_WINDOW_ADDR_GEN_Of_Colums,
  input  logic [BITWIDTH_W_COLUMS-1:0]    CONV_WINDOW_ADDR_GEN_W_Colums_1,
  input  logic [BITWIDTH_MAX_W_SIZE-1:0]  CONV_WINDOW_ADDR_GEN_W_ROXCL_1,
  input  logic [BITWIDTH_MAX_W_SIZE-1:0]  CONV_WINDOW_ADDR_GEN_W_Size_1,
  input  logic [BITWIDTH_STRIDE-1:0]      CONV_WINDOW_ADDR_GEN_Stride,
  input  logic                            CONV_WINDOW_ADDR_GEN_Ready,
  output logic                            CONV_WINDOW_ADDR_GEN_Valid,
  output logic [BITWIDTH_MAX_IF_SIZE-1:0] CONV_WINDOW_ADDR_GEN_If_Addr,
  output logic [BITWIDTH_MAX_W_SIZE-1:0]  CONV_WINDOW_ADDR_GEN_W_Addr,
  output logic                            CONV_WINDOW_ADDR_GEN_Win_Last,
  output logic                            CONV_WINDOW_ADDR_GEN_Busy,
  output logic                            CONV_WINDOW_ADDR_GEN_Done
);

  localparam int IFW = BITWIDTH_MAX_IF_SIZE;
  localparam int WW  = BITWIDTH_MAX_W_SIZE;

  logic                          clk;
  logic                          rst;
  logic [1:0]                    r_state;
  logic [IFW-1:0]                r_ifColums;
  logic [IFW-1:0]                r_ifRoxcl;
  logic [IFW-1:0]                r_sxc;
  logic [BITWIDTH_STRIDE-1:0]    r_stride;
  logic [BITWIDTH_W_COLUMS-1:0]  r_wColums1;
  logic [WW-1:0]                 r_wRoxcl1;
  logic [WW-1:0]                 r_wSize1;
  logic [BITWIDTH_IF_ROWS-1:0]   r_ofRows1;
  logic [BITWIDTH_IF_COLUMS-1:0] r_ofColums1;
  logic [IFW-1:0]                r_rowBase;
  logic [IFW-1:0]                r_winBase;
  logic [IFW-1:0]                r_chanPtr;
  logic [IFW-1:0]                r_rowPtr;
  logic [IFW-1:0]                r_ifAddr;
  logic [WW-1:0]                 r_wAddr;

  logic                          w_load;
  logic                          w_valid;
  logic                          w_accept;
  logic                          w_winEnd;
  logic                          w_wcWrap;
  logic                          w_chWrap;
  logic                          w_ocWrap;
  logic                          w_orWrap;
  logic                          w_lastBeat;
  logic                          w_emptyOf;
  logic [BITWIDTH_STRIDE-1:0]    w_strideIn;
  logic [IFW-1:0]                w_nextWin;
  logic [IFW-1:0]                w_nextChan;
  logic [IFW-1:0]                w_nextRow;
  logic [BITWIDTH_W_COLUMS-1:0]  w_wcLimit;
  logic [WW-1:0]                 w_chLimit;
  logic [BITWIDTH_IF_COLUMS-1:0] w_ocLimit;
  logic [BITWIDTH_IF_ROWS-1:0]   w_orLimit;

  assign clk = CONV_WINDOW_ADDR_GEN_CLOCK_50;
  assign rst = CONV_WINDOW_ADDR_GEN_RESET_InHigh;

  assign w_load     = (r_state == ST_LOAD);
  assign w_valid    = (r_state == ST_RUN);
  assign w_accept   = w_valid && CONV_WINDOW_ADDR_GEN_Ready;
  assign w_winEnd   = (r_wAddr == r_wSize1);
  assign w_lastBeat = w_winEnd && w_ocWrap && w_orWrap;
  assign w_emptyOf  = (CONV_WINDOW_ADDR_GEN_Of_Rows == '0) || (CONV_WINDOW_ADDR_GEN_Of_Colums == '0);
  assign w_strideIn = (CONV_WINDOW_ADDR_GEN_Stride == '0) ? BITWIDTH_STRIDE'(STRIDE_ZERO_AS)
                                                          : CONV_WINDOW_ADDR_GEN_Stride;

  assign w_nextWin  = w_ocWrap ? (r_rowBase + r_sxc) : (r_winBase + IFW'(r_stride));
  assign w_nextChan = r_chanPtr + r_ifRoxcl;
  assign w_nextRow  = r_rowPtr + r_ifColums;

  // Counters are cleared in LOAD, before the shadow registers hold the new limits.
  assign w_wcLimit = w_load ? CONV_WINDOW_ADDR_GEN_W_Colums_1 : r_wColums1;
  assign w_chLimit = w_load ? CONV_WINDOW_ADDR_GEN_W_ROXCL_1 : r_wRoxcl1;
  assign w_ocLimit = w_load ? (CONV_WINDOW_ADDR_GEN_Of_Colums - 1'b1) : r_ofColums1;
  assign w_orLimit = w_load ? (CONV_WINDOW_ADDR_GEN_Of_Rows - 1'b1) : r_ofRows1;

  wrap_counter #(.W(BITWIDTH_W_COLUMS)) u_wcCnt (
    .clk(clk), .rst(rst), .i_clear(w_load), .i_en(w_accept),
    .i_limit(w_wcLimit), .o_atLimit(w_wcWrap)
  );

  wrap_counter #(.W(WW)) u_chCnt (
    .clk(clk), .rst(rst), .i_clear(w_load), .i_en(w_accept),
    .i_limit(w_chLimit), .o_atLimit(w_chWrap)
  );

  wrap_counter #(.W(BITWIDTH_IF_COLUMS)) u_ocCnt (
    .clk(clk), .rst(rst), .i_clear(w_load), .i_en(w_accept && w_winEnd),
    .i_limit(w_ocLimit), .o_atLimit(w_ocWrap)
  );

  wrap_counter #(.W(BITWIDTH_IF_ROWS)) u_orCnt (
    .clk(clk), .rst(rst), .i_clear(w_load), .i_en(w_accept && w_winEnd && w_ocWrap),
    .i_limit(w_orLimit), .o_atLimit(w_orWrap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (CONV_WINDOW_ADDR_GEN_Start) r_state <= ST_LOAD;
        ST_LOAD: r_state <= w_emptyOf ? ST_DONE : ST_RUN;
        ST_RUN:  if (w_accept && w_lastBeat) r_state <= ST_DONE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // The S*If_Colums product is the only multiply and is formed once per run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ifColums  <= '0;
      r_ifRoxcl   <= '0;
      r_sxc       <= '0;
      r_stride    <= '0;
      r_wColums1  <= '0;
      r_wRoxcl1   <= '0;
      r_wSize1    <= '0;
      r_ofRows1   <= '0;
      r_ofColums1 <= '0;
      r_rowBase   <= '0;
      r_winBase   <= '0;
      r_chanPtr   <= '0;
      r_rowPtr    <= '0;
      r_ifAddr    <= '0;
      r_wAddr     <= '0;
    end else if (w_load) begin
      r_ifColums  <= IFW'(CONV_WINDOW_ADDR_GEN_If_Colums);
      r_ifRoxcl   <= CONV_WINDOW_ADDR_GEN_If_RoXCl;
      r_sxc       <= IFW'(w_strideIn) * IFW'(CONV_WINDOW_ADDR_GEN_If_Colums);
      r_stride    <= w_strideIn;
      r_wColums1  <= CONV_WINDOW_ADDR_GEN_W_Colums_1;
      r_wRoxcl1   <= CONV_WINDOW_ADDR_GEN_W_ROXCL_1;
      r_wSize1    <= CONV_WINDOW_ADDR_GEN_W_Size_1;
      r_ofRows1   <= w_orLimit;
      r_ofColums1 <= w_ocLimit;
      r_rowBase   <= '0;
      r_winBase   <= '0;
      r_chanPtr   <= '0;
      r_rowPtr    <= '0;
      r_ifAddr    <= '0;
      r_wAddr     <= '0;
    end else if (w_accept) begin
      if (w_winEnd) begin
        if (w_ocWrap) r_rowBase <= w_nextWin;
        r_winBase <= w_nextWin;
        r_chanPtr <= w_nextWin;
        r_rowPtr  <= w_nextWin;
        r_ifAddr  <= w_nextWin;
        r_wAddr   <= '0;
      end else begin
        r_wAddr <= r_wAddr + 1'b1;
        if (w_chWrap) begin
          r_chanPtr <= w_nextChan;
          r_rowPtr  <= w_nextChan;
          r_ifAddr  <= w_nextChan;
        end else if (w_wcWrap) begin
          r_rowPtr <= w_nextRow;
          r_ifAddr <= w_nextRow;
        end else begin
          r_ifAddr <= r_ifAddr + 1'b1;
        end
      end
    end
  end

  assign CONV_WINDOW_ADDR_GEN_Valid    = w_valid;
  assign CONV_WINDOW_ADDR_GEN_If_Addr  = r_ifAddr;
  assign CONV_WINDOW_ADDR_GEN_W_Addr   = r_wAddr;
  assign CONV_WINDOW_ADDR_GEN_Win_Last = w_valid && w_winEnd;
  assign CONV_WINDOW_ADDR_GEN_Busy     = (r_state != ST_IDLE);
  assign CONV_WINDOW_ADDR_GEN_Done     = (r_state == ST_DONE);

endmodule

// File: tb/tb_conv_window_addr_gen.sv
// Directed bench for conv_window_addr_gen: hand-computed window addresses plus a
// closed-form address model checked against every streamed beat.
module tb_conv_window_addr_gen;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [10:0] ifColums = '0;
  logic [21:0] ifRoxcl = '0;
  logic [9:0]  ofRows = '0;
  logic [10:0] ofColums = '0;
  logic [3:0]  wColums1 = '0;
  logic [8:0]  wRoxcl1 = '0;
  logic [8:0]  wSize1 = '0;
  logic [3:0]  stride = '0;
  logic        ready = 1'b0;

  logic        valid;
  logic [21:0] ifAddr;
  logic [8:0]  wAddr;
  logic        winLast;
  logic        busy;
  logic        done;

  int checks = 0;
  int failures = 0;
  int beatIf[$];
  int beatW[$];
  int beatLast[$];
  int doneSeen;

  always #5 clock = ~clock;

  conv_window_addr_gen dut (
    .CONV_WINDOW_ADDR_GEN_CLOCK_50    (clock),
    .CONV_WINDOW_ADDR_GEN_RESET_InHigh(reset),
    .CONV_WINDOW_ADDR_GEN_Start       (start),
    .CONV_WINDOW_ADDR_GEN_If_Colums   (ifColums),
    .CONV_WINDOW_ADDR_GEN_If_RoXCl    (ifRoxcl),
    .CONV_WINDOW_ADDR_GEN_Of_Rows     (ofRows),
    .CONV_WINDOW_ADDR_GEN_Of_Colums   (ofColums),
    .CONV_WINDOW_ADDR_GEN_W_Colums_1  (wColums1),
    .CONV_WINDOW_ADDR_GEN_W_ROXCL_1   (wRoxcl1),
    .CONV_WINDOW_ADDR_GEN_W_Size_1    (wSize1),
    .CONV_WINDOW_ADDR_GEN_Stride      (stride),
    .CONV_WINDOW_ADDR_GEN_Ready       (ready),
    .CONV_WINDOW_ADDR_GEN_Valid       (valid),
    .CONV_WINDOW_ADDR_GEN_If_Addr     (ifAddr),
    .CONV_WINDOW_ADDR_GEN_W_Addr      (wAddr),
    .CONV_WINDOW_ADDR_GEN_Win_Last    (winLast),
    .CONV_WINDOW_ADDR_GEN_Busy        (busy),
    .CONV_WINDOW_ADDR_GEN_Done        (done)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Programs the configuration and pulses Start for one clock; returns in the LOAD cycle.
  task automatic applyStimulus(input int ic, input int rxc, input int orows, input int ocols,
                               input int wc1, input int wr1, input int ws1, input int s);
    @(negedge clock);
    ifColums = 11'(ic);
    ifRoxcl  = 22'(rxc);
    ofRows   = 10'(orows);
    ofColums = 11'(ocols);
    wColums1 = 4'(wc1);
    wRoxcl1  = 9'(wr1);
    wSize1   = 9'(ws1);
    stride   = 4'(s);
    start    = 1'b1;
    @(negedge clock);
    start    = 1'b0;
  endtask

  task automatic checkStartup(input string name);
    checkOutput({name, " busy in load"}, busy, 1);
    checkOutput({name, " valid in load"}, valid, 0);
    @(negedge clock);
    checkOutput({name, " first valid"}, valid, 1);
    checkOutput({name, " first if addr"}, ifAddr, 0);
    checkOutput({name, " first w addr"}, wAddr, 0);
  endtask

  function automatic int modelIf(input int n);
    int s, wsz, pix, e, orr, oc, ch, r, wr, wc;
    s   = (stride == 0) ? 1 : int'(stride);
    wsz = int'(wSize1) + 1;
    pix = n / wsz;
    e   = n % wsz;
    orr = pix / int'(ofColums);
    oc  = pix % int'(ofColums);
    ch  = e / (int'(wRoxcl1) + 1);
    r   = e % (int'(wRoxcl1) + 1);
    wr  = r / (int'(wColums1) + 1);
    wc  = r % (int'(wColums1) + 1);
    return ch * int'(ifRoxcl) + (orr * s + wr) * int'(ifColums) + oc * s + wc;
  endfunction

  function automatic int beatIfAt(input int i);
    return (i < beatIf.size()) ? beatIf[i] : -1;
  endfunction

  // Runs the stream to Done, recording accepted beats and checking hold behaviour under backpressure.
  task automatic collectBeats(input string name, input bit dropReady, input bit glitchStart);
    int lastAccept;
    int lowLeft;
    bit dropped;
    bit holdPending;
    logic [21:0] hIf;
    logic [8:0] hW;
    logic hLast;
    beatIf.delete();
    beatW.delete();
    beatLast.delete();
    lastAccept = -10;
    lowLeft = 0;
    dropped = 1'b0;
    holdPending = 1'b0;
    doneSeen = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (holdPending) begin
        checkOutput({name, " hold valid"}, valid, 1);
        checkOutput({name, " hold if addr"}, ifAddr, hIf);
        checkOutput({name, " hold w addr"}, wAddr, hW);
        checkOutput({name, " hold win last"}, winLast, hLast);
        holdPending = 1'b0;
      end
      if (done) begin
        checkOutput({name, " done one cycle after last beat"}, cyc - lastAccept, 1);
        checkOutput({name, " valid low at done"}, valid, 0);
        checkOutput({name, " busy at done"}, busy, 1);
        doneSeen = 1;
        break;
      end
      if (dropReady && !dropped && beatIf.size() == 2) begin
        lowLeft = 3;
        dropped = 1'b1;
      end
      ready = (lowLeft == 0);
      if (lowLeft > 0) lowLeft--;
      start = glitchStart && valid && (beatIf.size() == 5);
      if (valid && ready) begin
        beatIf.push_back(int'(ifAddr));
        beatW.push_back(int'(wAddr));
        beatLast.push_back(int'(winLast));
        lastAccept = cyc;
      end else if (valid) begin
        holdPending = 1'b1;
        hIf = ifAddr;
        hW = wAddr;
        hLast = winLast;
      end
      @(negedge clock);
    end
    start = 1'b0;
    ready = 1'b1;
    if (doneSeen == 0) checkOutput({name, " done within cycle budget"}, 0, 1);
    @(negedge clock);
    checkOutput({name, " busy cleared after done"}, busy, 0);
    checkOutput({name, " done single pulse"}, done, 0);
  endtask

  task automatic checkScoreboard(input string name, input int expCount);
    int n;
    checkOutput({name, " beat count"}, beatIf.size(), expCount);
    n = (beatIf.size() < expCount) ? beatIf.size() : expCount;
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s model if beat %0d", name, i), beatIf[i], modelIf(i));
      checkOutput($sformatf("%s model w beat %0d", name, i), beatW[i], i % (int'(wSize1) + 1));
      checkOutput($sformatf("%s model last beat %0d", name, i), beatLast[i],
                  int'((i % (int'(wSize1) + 1)) == int'(wSize1)));
    end
  endtask

  initial begin
    int t1Idx[12];
    int t1Exp[12];
    int t2Top[4];
    int t3If[8];
    t1Idx = '{0, 1, 2, 3, 4, 5, 6, 7, 12, 13, 14, 15};
    t1Exp = '{0, 1, 4, 5, 1, 2, 5, 6, 4, 5, 8, 9};
    t2Top = '{0, 2, 8, 10};
    t3If  = '{0, 1, 3, 4, 9, 10, 12, 13};

    #1;
    checkOutput("reset valid", valid, 0);
    checkOutput("reset if addr", ifAddr, 0);
    checkOutput("reset w addr", wAddr, 0);
    checkOutput("reset win last", winLast, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    @(negedge clock);
    reset = 1'b0;
    ready = 1'b1;

    $display("[TB] IF 4x4x1, W 2x2x1, S=1, OF 3x3");
    applyStimulus(4, 16, 3, 3, 1, 3, 3, 1);
    checkStartup("t1");
    collectBeats("t1", 1'b0, 1'b0);
    checkScoreboard("t1", 36);
    for (int i = 0; i < 12; i++)
      checkOutput($sformatf("t1 hand if beat %0d", t1Idx[i]), beatIfAt(t1Idx[i]), t1Exp[i]);
    checkOutput("t1 last if addr", beatIfAt(35), 15);

    $display("[TB] IF 4x4x1, W 2x2x1, S=2, OF 2x2");
    applyStimulus(4, 16, 2, 2, 1, 3, 3, 2);
    checkStartup("t2");
    collectBeats("t2", 1'b0, 1'b0);
    checkScoreboard("t2", 16);
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("t2 window %0d top left", i), beatIfAt(4 * i), t2Top[i]);
    for (int i = 0; i < beatLast.size(); i++)
      checkOutput($sformatf("t2 win last beat %0d", i), beatLast[i], int'((i % 4) == 3));

    $display("[TB] IF 3x3x2, W 2x2x2, S=1, OF 2x2");
    applyStimulus(3, 9, 2, 2, 1, 3, 7, 1);
    checkStartup("t3");
    collectBeats("t3", 1'b0, 1'b0);
    checkScoreboard("t3", 32);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("t3 window0 if %0d", i), beatIfAt(i), t3If[i]);
      checkOutput($sformatf("t3 window0 w %0d", i), (i < beatW.size()) ? beatW[i] : -1, i);
    end

    $display("[TB] backpressure and Start while busy, stride 0");
    applyStimulus(4, 16, 3, 3, 1, 3, 3, 0);
    checkStartup("t4");
    collectBeats("t4", 1'b1, 1'b1);
    checkScoreboard("t4", 36);

    $display("[TB] reset mid-run");
    applyStimulus(4, 16, 3, 3, 1, 3, 3, 1);
    repeat (8) @(negedge clock);
    checkOutput("t5 running before reset", valid, 1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("t5 valid drops on reset", valid, 0);
    checkOutput("t5 busy drops on reset", busy, 0);
    checkOutput("t5 if addr cleared", ifAddr, 0);
    checkOutput("t5 done during reset", done, 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("t5 no done after reset", done, 0);
    checkOutput("t5 idle after reset", busy, 0);
    applyStimulus(4, 16, 3, 3, 1, 3, 3, 1);
    checkStartup("t5 restart");
    collectBeats("t5", 1'b0, 1'b0);
    checkScoreboard("t5", 36);

    $display("[TB] OF 0x3");
    applyStimulus(4, 16, 0, 3, 1, 3, 3, 1);
    checkOutput("t6 busy in load", busy, 1);
    checkOutput("t6 valid in load", valid, 0);
    @(negedge clock);
    checkOutput("t6 done two cycles after start", done, 1);
    checkOutput("t6 no valid", valid, 0);
    @(negedge clock);
    checkOutput("t6 done cleared", done, 0);
    checkOutput("t6 idle", busy, 0);
    checkOutput("t6 still no valid", valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_window_addr_gen.md
# conv_window_addr_gen

Sequential address generator that consumes the size-minus-one limits produced by the accelerator's dimension calculator and walks them. For every output-feature pixel in raster order, it emits the input-feature and weight memory addresses of each element in that pixel's convolution window, streamed over a valid/ready handshake into the MAC datapath. It sits between the configuration/limit logic and the IF/W memory read ports.

## Interface
- BITWIDTH_MAX_IF_SIZE, 22, IF address width; also the width of the IF plane size
- BITWIDTH_MAX_W_SIZE, 9, weight address width
- BITWIDTH_IF_ROWS, 10, OF row count width
- BITWIDTH_IF_COLUMS, 11, IF/OF column count width
- BITWIDTH_W_COLUMS, 4, weight column width
- BITWIDTH_STRIDE, 4, stride width

Clock and reset: one clock; reset is asynchronous and active-high.
- CONV_WINDOW_ADDR_GEN_CLOCK_50  in  1  system clock
- CONV_WINDOW_ADDR_GEN_RESET_InHigh  in  1  async active-high reset
- CONV_WINDOW_ADDR_GEN_Start  in  1  start pulse; sampled only in IDLE
- CONV_WINDOW_ADDR_GEN_If_Colums  in  BITWIDTH_IF_COLUMS  IF columns
- CONV_WINDOW_ADDR_GEN_If_RoXCl  in  BITWIDTH_MAX_IF_SIZE  IF rows*columns (channel plane size)
- CONV_WINDOW_ADDR_GEN_Of_Rows  in  BITWIDTH_IF_ROWS  OF rows
- CONV_WINDOW_ADDR_GEN_Of_Colums  in  BITWIDTH_IF_COLUMS  OF columns
- CONV_WINDOW_ADDR_GEN_W_Colums_1  in  BITWIDTH_W_COLUMS  weight columns - 1
- CONV_WINDOW_ADDR_GEN_W_ROXCL_1  in  BITWIDTH_MAX_W_SIZE  weight rows*columns - 1
- CONV_WINDOW_ADDR_GEN_W_Size_1  in  BITWIDTH_MAX_W_SIZE  weight rows*columns*channels - 1
- CONV_WINDOW_ADDR_GEN_Stride  in  BITWIDTH_STRIDE  stride; 0 is treated as 1
- CONV_WINDOW_ADDR_GEN_Ready  in  1  downstream accepts the current beat
- CONV_WINDOW_ADDR_GEN_Valid  out  1  If_Addr/W_Addr are valid
- CONV_WINDOW_ADDR_GEN_If_Addr  out  BITWIDTH_MAX_IF_SIZE  IF read address
- CONV_WINDOW_ADDR_GEN_W_Addr  out  BITWIDTH_MAX_W_SIZE  weight read address
- CONV_WINDOW_ADDR_GEN_Win_Last  out  1  current beat is the last element of the window
- CONV_WINDOW_ADDR_GEN_Busy  out  1  high in LOAD/RUN/DONE
- CONV_WINDOW_ADDR_GEN_Done  out  1  one-cycle pulse after the final beat

## Operation
- Address formula: If_Addr = c*If_RoXCl + (or*S + wr)*If_Colums + oc*S + wc.
  - W_Addr = c*(W_ROXCL_1+1) + wr*(W_Colums_1+1) + wc, running linearly 0..W_Size_1.
- Loop order, outer to inner: or, oc, c, wr, wc.
- All addresses are computed incrementally with adders; no multipliers in RUN:
  - wc step: +1.
  - wc wrap: row_ptr += If_Colums.
  - Channel wrap, detected when the in-channel index equals W_ROXCL_1: chan_ptr += If_RoXCl.
  - Window end: win_base += S.
  - OF row end: row_base += S*If_Colums. This product is formed once in LOAD by a single registered multiply.
- States:
  - IDLE: on Start go to LOAD.
  - LOAD: latch all inputs into shadow registers and compute S*If_Colums. If Of_Rows==0 or Of_Colums==0, go to DONE with no beats; otherwise go to RUN.
  - RUN: on the final beat accepted (Valid&Ready), go to DONE.
  - DONE: Done=1, then IDLE.
- Start outside IDLE is ignored. Input changes after LOAD are ignored until the next Start.
- Win_Last = Valid && W_Addr==W_Size_1.
- Address arithmetic is modulo 2^width. Overflow is the caller's responsibility and is not flagged.

## Timing
- Reset values: Valid=0, If_Addr=0, W_Addr=0, Win_Last=0, Busy=0, Done=0, state IDLE.
- Start sampled at edge k: Busy=1 from k+1; Valid=1 with If_Addr=0, W_Addr=0 from k+2.
- Each cycle with Valid&Ready advances exactly one element. Throughput is 1 beat/cycle while Ready=1.
- Valid&!Ready holds all outputs stable. Valid never drops before acceptance.
- The cycle after the final accept: Valid=0, Done=1, Busy=1. The next cycle: IDLE, Busy=0.
- Beat count is (Of_Rows*Of_Colums)*(W_Size_1+1).
- Reset asserted mid-run clears outputs asynchronously. No Done pulse is issued.

## Structure
- Shared package holds:
  - state encoding (IDLE, LOAD, RUN, DONE);
  - the width parameter defaults;
  - the stride-zero-as-one rule as a named constant.
- One natural sub-module, `wrap_counter`: a width-parameterized counter with enable, limit input, registered wrap flag and async reset.
  - Instanced for wc, the in-channel index, oc, and or.

## Test plan
- IF 4x4x1, W 2x2x1 (W_Colums_1=1, W_ROXCL_1=3, W_Size_1=3), S=1, OF 3x3, Ready=1:
  - window 0 If_Addr 0,1,4,5; window 1: 1,2,5,6; window 3: 4,5,8,9;
  - 36 beats total, last If_Addr 15, Done 1 cycle after.
- Same IF/W, S=2, OF 2x2 -> window top-left addresses 0,2,8,10; Win_Last on every 4th beat.
- IF 3x3x2 (If_RoXCl=9), W 2x2x2 (W_Size_1=7), S=1, OF 2x2:
  - window 0 If_Addr 0,1,3,4,9,10,12,13 with W_Addr 0..7.
- Ready toggled low for 3 cycles mid-window -> If_Addr/W_Addr/Win_Last stable; no skipped or duplicated element (scoreboard vs formula).
- Edge cases:
  - Reset mid-run -> Valid/Busy drop immediately, no Done; a subsequent Start restarts at address 0.
  - Start while Busy -> ignored.
  - OF 0x3 -> Done 2 cycles after Start, no Valid.
